// File: rtl/bnn_psum_threshold_unit.sv
// rtl/bnn_psum_threshold_unit.sv - accumulate psum beats per pixel, threshold to one bit, pack bits into words
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   en                  advance enable for the accumulate/pack path (output handshake ignores it)
//   psum_valid/ready    partial popcount input handshake, psum_in unsigned
//   thr_load            samples threshold_in / invert_in into the threshold registers
//   out_valid/ready     packed activation word handshake, out_data bit 0 = first pixel
//   sat_flag            sticky, set when any accumulation saturated
module bnn_psum_threshold_unit #(
    parameter int PSUM_WIDTH = 4,
    parameter int ACC_WIDTH  = 12,
    parameter int CHANNELS   = 16,
    parameter int PACK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  thr_load,
    input  logic [ACC_WIDTH-1:0]  threshold_in,
    input  logic                  invert_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic                  sat_flag
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;
    localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(PACK_WIDTH - 1);

    logic [0:0]            state_q,     state_d;
    logic [ACC_WIDTH-1:0]  acc_q,       acc_d;
    logic [CH_W-1:0]       ch_cnt_q,    ch_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [PACK_WIDTH-1:0] pack_q,      pack_d;
    logic [ACC_WIDTH-1:0]  thr_q,       thr_d;
    logic                  inv_q,       inv_d;
    logic [PACK_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  sat_q,       sat_d;

    logic                  beat;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  act_bit;
    logic [PACK_WIDTH-1:0] word;
    logic                  slot_free;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ch_cnt_d    = ch_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        pack_d      = pack_q;
        thr_d       = thr_q;
        inv_d       = inv_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        psum_ready = (state_q == ST_RUN);
        beat       = psum_valid && psum_ready && en;

        // One extra bit catches the carry out; that carry is the saturation event.
        acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}}, psum_in};
        acc_next = acc_sum[ACC_WIDTH] ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];

        // Compare uses the threshold registered before any same-cycle thr_load.
        act_bit        = (acc_next >= thr_q) ^ inv_q;
        word           = pack_q;
        word[bit_cnt_q] = act_bit;

        slot_free = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == ST_STALL) begin
            // Output register is full and pack_q holds the next word; move it across
            // on the same edge the current word is taken.
            if (out_ready) begin
                out_data_d  = pack_q;
                out_valid_d = 1'b1;
                pack_d      = '0;
                state_d     = ST_RUN;
            end
        end else if (beat) begin
            if (acc_sum[ACC_WIDTH]) begin
                sat_d = 1'b1;
            end
            if (ch_cnt_q == CH_LAST) begin
                acc_d    = '0;
                ch_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (slot_free) begin
                        out_data_d  = word;
                        out_valid_d = 1'b1;
                        pack_d      = '0;
                    end else begin
                        pack_d  = word;
                        state_d = ST_STALL;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    pack_d    = word;
                end
            end else begin
                acc_d    = acc_next;
                ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
        end

        if (thr_load) begin
            thr_d = threshold_in;
            inv_d = invert_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            pack_q      <= '0;
            thr_q       <= '0;
            inv_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            pack_q      <= pack_d;
            thr_q       <= thr_d;
            inv_q       <= inv_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule

// File: doc/bnn_psum_threshold_unit.md
Name: bnn_psum_threshold_unit

Overview:
- Downstream consumer of the XNOR convolution PE column outputs.
- Accumulates CHANNELS partial popcounts per output pixel and compares the sum to a programmable batch-norm-folded threshold, giving one binary activation bit per pixel.
- Packs PACK_WIDTH activation bits into a word and hands it to the next layer's line buffer through a valid/ready handshake.

Parameters:
PSUM_WIDTH, 4, width of incoming partial popcount (matches PE pcountout)
ACC_WIDTH, 12, accumulator and threshold width
CHANNELS, 16, psum beats accumulated per pixel (>=1)
PACK_WIDTH, 8, activation bits per output word (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
en  in  1  advance enable for accumulate/pack logic
psum_valid  in  1  psum_in beat present
psum_ready  out  1  unit can accept a beat this cycle
psum_in  in  PSUM_WIDTH  partial popcount from PE column (unsigned)
thr_load  in  1  load threshold_in/invert_in
threshold_in  in  ACC_WIDTH  unsigned threshold
invert_in  in  1  flip activation polarity (negative BN gamma)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  PACK_WIDTH  packed activations; first pixel in bit 0
sat_flag  out  1  sticky: an accumulator saturated

Behaviour:
- Reset (rst=0 at posedge): acc=0, ch_cnt=0, bit_cnt=0, pack_reg=0, thr_reg=0, inv_reg=0, out_data=0, out_valid=0, sat_flag=0, state=RUN. Reset mid-word discards partial data with no output.
- Beat accepted when psum_valid && psum_ready && en. If en=0, no beat is accepted and acc, counters and pack_reg hold. The output handshake still completes with en=0.
- Accumulate: acc_next = acc + zero-extended psum_in, saturating at 2^ACC_WIDTH-1. Saturation sets sat_flag, which is cleared only by reset.
- Final beat (ch_cnt==CHANNELS-1):
  - bit = (acc_next >= thr_reg) XOR inv_reg, unsigned compare.
  - bit is written to pack_reg[bit_cnt]; acc and ch_cnt clear to 0; bit_cnt increments.
  - Any other beat increments ch_cnt only.
- Word completion (final beat with bit_cnt==PACK_WIDTH-1): bit_cnt wraps to 0, then one of:
  - Out slot free (out_valid==0, or out_ready==1 this cycle): out_data <= completed word and out_valid=1 next cycle. Latency from last beat to out_valid is 1 cycle.
  - Out slot busy: go to STALL; the completed word stays in pack_reg.
- STALL:
  - psum_ready=0.
  - On a cycle with out_ready=1, out_data <= pack_reg, out_valid stays 1, pack_reg clears, return to RUN.
- psum_ready is 1 in RUN and 0 in STALL, registered from state. Back-to-back beats are accepted every cycle in RUN.
- Output handshake:
  - out_valid holds and out_data stays stable until out_ready.
  - out_valid drops the cycle after the transfer unless a new word is loaded in that same cycle.
- Threshold load: thr_load samples threshold_in/invert_in into thr_reg/inv_reg. If thr_load and a final beat occur in the same cycle, the compare uses the old thr_reg.
- Width rule: ACC_WIDTH must be >= PSUM_WIDTH + clog2(CHANNELS); otherwise saturation behaviour governs.
- States: RUN, STALL only.

Test Plan:
1. thr=20, inv=0, CHANNELS=16, psum_in=1 ×16 -> sum 16 <20, bit0=0; psum_in=2 ×16 -> sum 32, bit1=1; after 8 pixels alternating, out_data=8'hAA, out_valid 1 cycle after last beat.
2. Same stream with inv=1 -> out_data=8'h55.
3. out_ready held 0 while two words complete -> first word held stable, unit enters STALL, psum_ready=0. Raise out_ready -> first word transfers, second word appears next cycle, no beat lost.
4. ACC_WIDTH=6, psum_in=15 ×16 -> acc saturates at 63, sat_flag=1 and stays 1. Bit=1 with thr=63.
5. thr_load (thr=0→100) in the same cycle as a pixel's final beat, sum 50 -> bit=1 (old thr). Next pixel with sum 50 -> bit=0.
6. rst=0 after 5 pixels and 7 beats of pixel 6 -> all outputs 0, no word emitted. The next 8 pixels produce a clean word in bits 0..7.
